// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for a 5-stage pipeline (IF/ID, ID/EXE,
//   EXE/MEM, MEM/WB). Detects load-use hazards, taken-branch redirects and
//   instruction/data memory wait states, and drives the hold (stall_*) and
//   bubble (flush_*) controls of each stage register.
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     id_rs1/id_rs2       : source registers of the instruction in ID
//     id_use_rs1/rs2      : ID instruction actually reads rs1/rs2
//     exe_rd, exe_is_load : destination / load flag of the EXE instruction
//     exe_br_taken        : EXE branch/jump resolved taken
//     if_req, if_ready    : instruction fetch outstanding / data returned
//     mem_req, mem_ready  : data access active / access completes
//     stall_pc..stall_wb  : hold controls for PC and stage registers
//     flush_id, flush_exe : load a bubble into IF/ID, ID/EXE
//     pc_redirect         : PC loads the branch target
//     stall_cnt           : number of cycles with stall_pc=1 (wraps)
//     bus_err             : sticky, a memory wait exceeded TIMEOUT cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       exe_rd,
    input  logic             exe_is_load,
    input  logic             exe_br_taken,
    input  logic             if_req,
    input  logic             if_ready,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_pc,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             stall_mem,
    output logic             stall_wb,
    output logic             flush_id,
    output logic             flush_exe,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             bus_err
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2
    } state_t;

    localparam logic [TO_W-1:0]  TIMEOUT_V = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  WAIT_MAX  = {TO_W{1'b1}};
    localparam logic [TO_W-1:0]  WAIT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nxt_s;
    logic              drop_fetch_r;
    logic              drop_fetch_nxt_s;
    logic [TO_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              bus_err_r;

    logic              dstall_s;
    logic              istall_s;
    logic              lu_s;
    logic              waiting_s;
    logic              ready_edge_s;

    assign dstall_s = mem_req & ~mem_ready;
    assign istall_s = if_req & ~if_ready;
    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lu_s = exe_is_load & (exe_rd != 5'd0) &
                  ((id_use_rs1 & (id_rs1 == exe_rd)) |
                   (id_use_rs2 & (id_rs2 == exe_rd)));

    assign stall_cnt = stall_cnt_r;
    assign bus_err   = bus_err_r;

    // Prioritised hazard resolution: stall/flush/redirect controls and drop flag update.
    always_comb begin
        stall_pc         = 1'b0;
        stall_id         = 1'b0;
        stall_exe        = 1'b0;
        stall_mem        = 1'b0;
        stall_wb         = 1'b0;
        flush_id         = 1'b0;
        flush_exe        = 1'b0;
        pc_redirect      = 1'b0;
        drop_fetch_nxt_s = drop_fetch_r;
        if (rst) begin
            drop_fetch_nxt_s = 1'b0;
        end else if (dstall_s) begin
            // Freeze the whole pipe; a taken branch in EXE is re-evaluated later.
            stall_pc  = 1'b1;
            stall_id  = 1'b1;
            stall_exe = 1'b1;
            stall_mem = 1'b1;
            stall_wb  = 1'b1;
        end else if (exe_br_taken) begin
            pc_redirect = 1'b1;
            flush_id    = 1'b1;
            flush_exe   = 1'b1;
            // An abandoned fetch still in flight returns a stale word later.
            // A word arriving now is already flushed, so nothing stays pending.
            if (istall_s) begin
                drop_fetch_nxt_s = 1'b1;
            end else if (if_ready) begin
                drop_fetch_nxt_s = 1'b0;
            end else begin
                drop_fetch_nxt_s = drop_fetch_r;
            end
        end else if (lu_s) begin
            // One bubble suffices: next cycle the load is in MEM and forwards.
            stall_pc  = 1'b1;
            stall_id  = 1'b1;
            flush_exe = 1'b1;
        end else if (istall_s) begin
            stall_pc = 1'b1;
            flush_id = 1'b1;
        end else if (if_ready && drop_fetch_r) begin
            stall_pc         = 1'b1;
            flush_id         = 1'b1;
            drop_fetch_nxt_s = 1'b0;
        end else begin
            drop_fetch_nxt_s = drop_fetch_r;
        end
    end

    // Wait-state FSM next state, plus "still waiting" and "wait ended" qualifiers.
    always_comb begin
        state_nxt_s  = state_r;
        waiting_s    = 1'b0;
        ready_edge_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (dstall_s) begin
                    state_nxt_s = ST_DWAIT;
                end else if (istall_s) begin
                    state_nxt_s = ST_IWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DWAIT: begin
                if (mem_ready) begin
                    state_nxt_s  = ST_RUN;
                    ready_edge_s = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            ST_IWAIT: begin
                // A data stall takes over without resetting the wait budget.
                if (dstall_s) begin
                    state_nxt_s = ST_DWAIT;
                    waiting_s   = 1'b1;
                end else if (if_ready) begin
                    state_nxt_s  = ST_RUN;
                    ready_edge_s = 1'b1;
                end else begin
                    waiting_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State, drop flag, wait/stall counters and sticky bus error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            drop_fetch_r <= 1'b0;
            wait_cnt_r   <= {TO_W{1'b0}};
            stall_cnt_r  <= {CNT_W{1'b0}};
            bus_err_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            drop_fetch_r <= drop_fetch_nxt_s;
            if ((state_r == ST_RUN) || ready_edge_s) begin
                wait_cnt_r <= {TO_W{1'b0}};
            end else if (wait_cnt_r != WAIT_MAX) begin
                wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if (waiting_s && (wait_cnt_r == TIMEOUT_V)) begin
                bus_err_r <= 1'b1;
            end else begin
                bus_err_r <= bus_err_r;
            end
            if (stall_pc) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rs1, id_rs2, exe_rd;
    logic        id_use_rs1, id_use_rs2, exe_is_load, exe_br_taken;
    logic        if_req, if_ready, mem_req, mem_ready;
    logic        stall_pc, stall_id, stall_exe, stall_mem, stall_wb;
    logic        flush_id, flush_exe, pc_redirect;
    logic [31:0] stall_cnt;
    logic        bus_err;

    pipe_hazard_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .exe_rd(exe_rd), .exe_is_load(exe_is_load), .exe_br_taken(exe_br_taken),
        .if_req(if_req), .if_ready(if_ready),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall_pc(stall_pc), .stall_id(stall_id), .stall_exe(stall_exe),
        .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush_id(flush_id), .flush_exe(flush_exe), .pc_redirect(pc_redirect),
        .stall_cnt(stall_cnt), .bus_err(bus_err)
    );

    // output bundle order: {stall_pc,stall_id,stall_exe,stall_mem,stall_wb,flush_id,flush_exe,pc_redirect}
    localparam logic [7:0] O_NONE = 8'b00000_000;
    localparam logic [7:0] O_ALL5 = 8'b11111_000;
    localparam logic [7:0] O_BR   = 8'b00000_111;
    localparam logic [7:0] O_LU   = 8'b11000_010;
    localparam logic [7:0] O_IS   = 8'b10000_100;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ld, br, iq, ir, mq, mr;
        logic [7:0] exp;
    } vec_t;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_cnt   = 32'd0;
    logic        exp_err   = 1'b0;

    function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u1, input logic u2,
                                input logic ld, input logic br, input logic iq, input logic ir,
                                input logic mq, input logic mr, input logic [7:0] e);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.ld = ld; v.br = br;
        v.iq = iq; v.ir = ir; v.mq = mq; v.mr = mr; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    // One clock cycle: drive, check mid-cycle at negedge, update model at posedge.
    task automatic cycle(input vec_t v, input logic r);
        rst = r;
        id_rs1 = v.rs1; id_rs2 = v.rs2; exe_rd = v.rd;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; exe_is_load = v.ld; exe_br_taken = v.br;
        if_req = v.iq; if_ready = v.ir; mem_req = v.mq; mem_ready = v.mr;
        @(negedge clk);
        chk({v.name, ".outs"},
            {24'd0, stall_pc, stall_id, stall_exe, stall_mem, stall_wb, flush_id, flush_exe, pc_redirect},
            {24'd0, v.exp});
        chk({v.name, ".stall_cnt"}, stall_cnt, exp_cnt);
        chk({v.name, ".bus_err"}, {31'd0, bus_err}, {31'd0, exp_err});
        @(posedge clk);
        if (r) begin
            exp_cnt = 32'd0;
            exp_err = 1'b0;
        end else if (v.exp[7]) begin
            exp_cnt = exp_cnt + 32'd1;
        end
        #1;
    endtask

    vec_t tbl[17];
    vec_t z, d;

    initial begin
        tbl[0]  = mk("idle",          5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
        tbl[1]  = mk("lu_rs1",        5'd5, 5'd0, 5'd5, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, O_LU);
        tbl[2]  = mk("lu_rd0",        5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
        tbl[3]  = mk("lu_rs2_unused", 5'd1, 5'd7, 5'd7, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
        tbl[4]  = mk("lu_rs2",        5'd1, 5'd7, 5'd7, 1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, O_LU);
        tbl[5]  = mk("ld_nomatch",    5'd6, 5'd0, 5'd5, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
        tbl[6]  = mk("alu_match",     5'd5, 5'd0, 5'd5, 1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, O_NONE);
        tbl[7]  = mk("dstall",        5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b0, O_ALL5);
        tbl[8]  = mk("dstall_all",    5'd5, 5'd0, 5'd5, 1'b1,1'b0,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0, O_ALL5);
        tbl[9]  = mk("br",            5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, O_BR);
        tbl[10] = mk("br_lu",         5'd5, 5'd0, 5'd5, 1'b1,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, O_BR);
        tbl[11] = mk("istall",        5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, O_IS);
        tbl[12] = mk("lu_istall",     5'd5, 5'd0, 5'd5, 1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, O_LU);
        tbl[13] = mk("mem_done",      5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,1'b1, O_NONE);
        tbl[14] = mk("fetch_done",    5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, O_NONE);
        tbl[15] = mk("br_ifready",    5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0, O_BR);
        tbl[16] = mk("ifready_nodrop",5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, O_NONE);
        z = tbl[0];
        d = tbl[7];

        // Reset: one edge to initialise, then check reset state while rst held.
        rst = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; exe_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; exe_is_load = 1'b0; exe_br_taken = 1'b0;
        if_req = 1'b0; if_ready = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        z.name = "reset";
        cycle(z, 1'b1);

        // Table-driven combinational priority checks.
        for (int i = 0; i < 17; i++) cycle(tbl[i], 1'b0);

        // Load-use: exactly one bubble, then the load has moved on to MEM.
        cycle(tbl[1], 1'b0);
        z.name = "lu_after";
        cycle(z, 1'b0);

        // Data stall over a taken branch for 3 cycles, then redirect on ready.
        begin
            vec_t v;
            v = mk("dstall_br", 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0, O_ALL5);
            for (int k = 0; k < 3; k++) cycle(v, 1'b0);
            v = mk("dstall_br_rdy", 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b1, O_BR);
            cycle(v, 1'b0);
        end

        // Branch abandons an outstanding fetch; its late response is discarded once.
        cycle(mk("br_istall",    5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0, O_BR), 1'b0);
        cycle(mk("stale_wait",   5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, O_IS), 1'b0);
        cycle(mk("stale_drop",   5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0, O_IS), 1'b0);
        cycle(mk("after_drop",   5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, O_NONE), 1'b0);

        // Reset in the middle of a data wait with a drop pending.
        cycle(mk("pre_rst_br",   5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0, O_BR), 1'b0);
        d.name = "pre_rst_dwait";
        cycle(d, 1'b0);
        cycle(d, 1'b0);
        d.name = "rst_in_dwait";
        d.exp = O_NONE;
        cycle(d, 1'b1);
        cycle(mk("post_rst_nodrop", 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, O_NONE), 1'b0);

        // Timeout: first stalled cycle in RUN, bus_err sets after the 5th DWAIT cycle.
        d = tbl[7];
        d.name = "timeout";
        for (int k = 0; k < 9; k++) begin
            cycle(d, 1'b0);
            if (k == 5) exp_err = 1'b1;
        end
        cycle(mk("err_sticky", 5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, O_NONE), 1'b0);
        z = tbl[0];
        z.name = "err_sticky2";
        cycle(z, 1'b0);
        z.name = "err_rst";
        cycle(z, 1'b1);
        z.name = "err_cleared";
        cycle(z, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
